// File: rtl/acc_if.sv
// Command and data bundle between the multiplier control FSM and the
// accumulator: the FSM side drives the commands, the accumulator drives Saidas.
interface acc_if;
    logic        Sh;
    logic        Ad;
    logic        Load;
    logic [32:0] Entradas;
    logic [32:0] Saidas;

    modport master (
        output Sh,
        output Ad,
        output Load,
        output Entradas,
        input  Saidas
    );

    modport slave (
        input  Sh,
        input  Ad,
        input  Load,
        input  Entradas,
        output Saidas
    );
endinterface

// File: rtl/acc.sv
// 33-bit accumulator of the 16x16 shift-and-add multiplier: [32:16] partial product, [15:0] multiplier.
// Optional macro ACC_ADDSH_EN: with Ad and Sh both high, add and shift are fused into one cycle.
module acc (
    input  logic Clk,
    input  logic Rst,
    acc_if.slave bus
);
    logic [32:0] acc_q;
    logic [32:0] acc_d;
    logic [16:0] sum;

    // Bit 32 is never an addend: the new carry replaces it.
    assign sum = {1'b0, acc_q[31:16]} + {1'b0, bus.Entradas[15:0]};

    always_comb begin
        acc_d = acc_q;
        if (bus.Load) begin
            acc_d = bus.Entradas;
        end else if (bus.Ad && bus.Sh) begin
`ifdef ACC_ADDSH_EN
            acc_d = {1'b0, sum, acc_q[15:1]};
`else
            acc_d = {sum, acc_q[15:0]};
`endif
        end else if (bus.Ad) begin
            acc_d = {sum, acc_q[15:0]};
        end else if (bus.Sh) begin
            acc_d = {1'b0, acc_q[32:1]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bus.Saidas = acc_q;
endmodule

// File: tb/tb_acc.sv
// Scoreboard bench for acc: every command pushes its expected word, which is
// popped and compared one edge later; directed checks add fixed constants.
module tb_acc;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [32:0] model_q;
    logic [32:0] exp_q[$];

    acc_if bus_if ();

    acc dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%09h expected=0x%09h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%09h", tag, got);
        end
    endtask

    // Reference behaviour written from the operation table, not from the RTL.
    function automatic logic [32:0] model(input logic [32:0] cur, input logic l,
                                          input logic a, input logic s, input logic [32:0] e);
        logic [16:0] partial;
        logic [32:0] added;
        partial = cur[31:16] + e[15:0];
        added   = cur;
        added[32:16] = partial;
        if (l) return e;
        if (a && s) begin
`ifdef ACC_ADDSH_EN
            return added >> 1;
`else
            return added;
`endif
        end
        if (a) return added;
        if (s) return cur >> 1;
        return cur;
    endfunction

    task automatic op(input logic r, input logic l, input logic a, input logic s,
                      input logic [32:0] e, input string tag);
        @(negedge clk);
        rst             = r;
        bus_if.Load     = l;
        bus_if.Ad       = a;
        bus_if.Sh       = s;
        bus_if.Entradas = e;
        model_q = r ? 33'd0 : model(model_q, l, a, s, e);
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            check(tag, bus_if.Saidas, exp_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_if.Load = 1'b0;
        bus_if.Ad = 1'b0;
        bus_if.Sh = 1'b0;
        bus_if.Entradas = '0;
        model_q = '0;

        op(1, 0, 0, 0, 33'd0, "reset");
        check("reset_val", bus_if.Saidas, 33'h000000000);

        op(0, 1, 0, 0, 33'd7, "load7");
        check("load7_val", bus_if.Saidas, 33'd7);
        op(0, 0, 0, 1, 33'd0, "sh");
        check("sh_val", bus_if.Saidas, 33'd3);
        op(0, 0, 1, 0, 33'd200, "ad200");
        check("ad200_val", bus_if.Saidas, 33'h000C80003);

        op(0, 1, 0, 0, 33'h0FFFF0000, "load_ffff");
        op(0, 0, 1, 0, 33'd1, "ad_carry");
        check("carry_val", bus_if.Saidas, 33'h100000000);
        op(0, 0, 0, 1, 33'd0, "sh_carry");
        check("sh_carry_val", bus_if.Saidas, 33'h080000000);

        // Bit 32 set before an add must be overwritten by the new carry.
        op(0, 1, 0, 0, 33'h100010000, "load_b32");
        op(0, 0, 1, 0, 33'h1FFFF0002, "ad_drop_b32");
        check("drop_b32_val", bus_if.Saidas, 33'h000030000);

        op(0, 1, 1, 0, 33'h000012345, "load_vs_ad");
        check("load_wins_val", bus_if.Saidas, 33'h000012345);

        op(0, 1, 0, 0, 33'd7, "load7b");
        op(0, 0, 1, 1, 33'd3, "ad_sh");
`ifdef ACC_ADDSH_EN
        check("ad_sh_val", bus_if.Saidas, 33'h000018003);
`else
        check("ad_sh_val", bus_if.Saidas, 33'h000030007);
`endif

        // 5 x 3 by shift-and-add, decisions taken from the model's LSB.
        op(0, 1, 0, 0, 33'd3, "mul_load");
        for (int i = 0; i < 16; i++) begin
            if (model_q[0]) op(0, 0, 1, 0, 33'd5, "mul_ad");
            op(0, 0, 0, 1, 33'd0, "mul_sh");
        end
        check("mul_result", bus_if.Saidas, 33'd15);

        // Reset during an add wins over the command.
        op(0, 1, 0, 0, 33'h0ABCD1234, "load_pre_rst");
        op(1, 0, 1, 0, 33'd99, "rst_mid_ad");
        check("rst_mid_val", bus_if.Saidas, 33'd0);

        op(0, 1, 0, 0, 33'h155550001, "load_hold");
        for (int i = 0; i < 3; i++) begin
            op(0, 0, 0, 0, 33'h1FFFFFFFF, "hold");
            check("hold_val", bus_if.Saidas, 33'h155550001);
        end

        for (int i = 0; i < 30; i++) begin
            logic [3:0] cmd;
            logic [32:0] ent;
            cmd = 4'($urandom_range(0, 15));
            ent = {1'($urandom), 32'($urandom)};
            op(cmd == 4'd0, cmd[1], cmd[2], cmd[3], ent, "random");
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
